// File: rtl/ifetch_buf_if.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | ifetch_buf_if : imem, redirect and decode-handshake bundle        |
// | rev 1.0                                                           |
// +-------------------------------------------------------------------+
interface ifetch_buf_if #(
  parameter int DEPTH   = 4,
  parameter int IMEM_AW = 6
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_data;
  logic               redirect;
  logic [31:0]        redirect_pc;
  logic               cmd_valid;
  logic [31:0]        cmd;
  logic [31:0]        cmd_pc;
  logic               cmd_ready;
  logic [CW-1:0]      count;

  // master is the fetch stage; slave is the imem/decode/branch side
  modport master (
    output imem_addr, cmd_valid, cmd, cmd_pc, count,
    input  imem_data, redirect, redirect_pc, cmd_ready
  );
  modport slave (
    input  imem_addr, cmd_valid, cmd, cmd_pc, count,
    output imem_data, redirect, redirect_pc, cmd_ready
  );
endinterface
`default_nettype wire

// File: rtl/ifetch_buf.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | ifetch_buf : fetch PC, combinational imem read, prefetch FIFO     |
// | rev 1.0                                                           |
// +-------------------------------------------------------------------+
module ifetch_buf #(
  parameter int          DEPTH    = 4,
  parameter int          IMEM_AW  = 6,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  wire logic      clk,
  input  wire logic      rst,
  ifetch_buf_if.master   bus
);
  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH + 1);
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

  logic [31:0]        r_fpc;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic [31:0]        r_ins [DEPTH];
  logic [31:0]        r_pc  [DEPTH];

  logic w_valid;
  logic w_pop;
  logic w_push;

  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid & bus.cmd_ready;
  // A full queue still accepts a fetch when the head leaves the same cycle.
  assign w_push  = ~bus.redirect & ((r_count < c_FULL) | w_pop);

  assign bus.imem_addr = r_fpc[IMEM_AW+1:2];
  assign bus.cmd_valid = w_valid;
  assign bus.cmd       = w_valid ? r_ins[r_rd_ptr] : 32'h0;
  assign bus.cmd_pc    = w_valid ? r_pc[r_rd_ptr]  : 32'h0;
  assign bus.count     = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fpc    <= RESET_PC;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.redirect) begin
      // A head consumed during redirect is dropped with the rest of the queue.
      r_fpc    <= {bus.redirect_pc[31:2], 2'b00};
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_fpc    <= r_fpc + 32'd4;
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)
        r_count <= r_count + 1'b1;
      else if (w_pop && !w_push)
        r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_ins[r_wr_ptr] <= bus.imem_data;
      r_pc[r_wr_ptr]  <= r_fpc;
    end
  end
endmodule
`default_nettype wire
